// File: rtl/fsub32_serial_pkg.sv
// ---------------------------------------------------------------------------
// fsub32_serial_pkg
// Shared constants and state encoding for the slice-serial 32-bit subtractor.
//   FSUB_WIDTH  : default operand/result width
//   FSUB_SLICE  : default bits processed per clock
//   FSUB_NSLICE : slices per operation
//   FSUB_IDXW   : width of the slice index register
//   state_t     : IDLE / BUSY / DONE controller states
// ---------------------------------------------------------------------------
package fsub32_serial_pkg;

  localparam int FSUB_WIDTH  = 32;
  localparam int FSUB_SLICE  = 8;
  localparam int FSUB_NSLICE = FSUB_WIDTH / FSUB_SLICE;
  localparam int FSUB_IDXW   = (FSUB_NSLICE > 1) ? $clog2(FSUB_NSLICE) : 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_BUSY = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fsub32_serial_sub_slice8.sv
// ---------------------------------------------------------------------------
// sub_slice8
// Combinational SLICE-bit subtract stage: diff = a - b - bin.
// Built as a + ~b + ~bin so a plain adder does the work; borrow is the
// inverse of the adder carry.
//   a    [SLICE] : minuend slice
//   b    [SLICE] : subtrahend slice
//   bin          : borrow-in
//   diff [SLICE] : difference slice
//   bout         : borrow-out
// ---------------------------------------------------------------------------
module sub_slice8 #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~bin};
  assign diff  = w_sum[SLICE-1:0];
  assign bout  = ~w_sum[SLICE];

endmodule

// File: rtl/fsub32_serial.sv
// ---------------------------------------------------------------------------
// fsub32_serial
// Multi-cycle subtractor d = x - y - bin, one SLICE-bit slice per clock,
// LSB slice first. The borrow ripples between slices only through a
// register, so the critical path is a single SLICE-bit adder.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   x, y, bin           : minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   d                   : difference mod 2^WIDTH
//   bout, zero, ovf     : borrow-out, d == 0, signed overflow
// ---------------------------------------------------------------------------
module fsub32_serial
  import fsub32_serial_pkg::*;
#(
  parameter int WIDTH = FSUB_WIDTH,
  parameter int SLICE = FSUB_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_cfg
    $error("fsub32_serial: WIDTH must be a multiple of SLICE");
  end

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic             r_borrow;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;
  logic             r_zero;
  logic             r_ovf;

  logic [SLICE-1:0] w_xs;
  logic [SLICE-1:0] w_ys;
  logic [SLICE-1:0] w_s;
  logic             w_bo;
  logic [WIDTH-1:0] w_d_next;
  logic             w_last;

  // Operand-slice select feeding the single shared slice stage.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_xs = '0;
    w_ys = '0;
    for (int i = 0; i < NSL; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_xs = r_x[i*SLICE +: SLICE];
        w_ys = r_y[i*SLICE +: SLICE];
      end
    end
  end

  sub_slice8 #(.SLICE(SLICE)) u_slice (
    .a    (w_xs),
    .b    (w_ys),
    .bin  (r_borrow),
    .diff (w_s),
    .bout (w_bo)
  );

  // Full difference as it will stand after this edge; on the last slice it
  // is the final result, which lets zero/ovf be registered on that same edge.
  always_comb begin
    w_d_next = r_d;
    for (int i = 0; i < NSL; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_d_next[i*SLICE +: SLICE] = w_s;
      end
    end
  end

  assign w_last = (r_idx == IDXW'(NSL - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x      <= x;
            r_y      <= y;
            r_borrow <= bin;
            r_d      <= '0;
            r_idx    <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_d      <= w_d_next;
          r_borrow <= w_bo;
          r_idx    <= r_idx + IDXW'(1);
          if (w_last) begin
            r_bout  <= w_bo;
            r_zero  <= (w_d_next == '0);
            // Overflow only when operand signs differ and the result sign
            // departs from the minuend sign.
            r_ovf   <= (r_x[WIDTH-1] ^ r_y[WIDTH-1]) &
                       (r_x[WIDTH-1] ^ w_d_next[WIDTH-1]);
            r_idx   <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign d         = r_d;
  assign bout      = r_bout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fsub32_serial.sv
// ---------------------------------------------------------------------------
// tb_fsub32_serial
// Directed bench for fsub32_serial. A reference model computes the expected
// result from plain wide arithmetic; a compare process checks every cycle
// out_valid is high, and the driver pins each vector to hand-computed values.
// ---------------------------------------------------------------------------
module tb_fsub32_serial;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] y;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bout;
  logic        zero;
  logic        ovf;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t exp_q[$];

  fsub32_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Subtraction model from the arithmetic definition, independent of slicing.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    exp_t        e;
    logic [32:0] w;
    longint      s;
    w      = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    e.d    = w[31:0];
    e.bout = w[32];
    e.zero = (w[31:0] == 32'd0);
    s      = longint'($signed(a)) - longint'($signed(b));
    if (bi) s = s - 1;
    e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return e;
  endfunction

  // Compare process: every cycle a result is presented it must match the
  // model, and the block must not be ready for new operands at the same time.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check("model_d",    64'(d),    64'(exp_q[0].d));
        check("model_bout", 64'(bout), 64'(exp_q[0].bout));
        check("model_zero", 64'(zero), 64'(exp_q[0].zero));
        check("model_ovf",  64'(ovf),  64'(exp_q[0].ovf));
        check("ready_in_done", 64'(in_ready), 64'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Present operands and wait (bounded) for the accept edge.
  task automatic accept(input logic [31:0] ax, input logic [31:0] ay, input logic abin,
                        output logic ok);
    int guard;
    x = ax; y = ay; bin = abin; in_valid = 1'b1;
    guard = 0;
    ok = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      ok = 1'b0;
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(model(ax, ay, abin));
      #1;
      in_valid = 1'b0;
      x = ~ax; y = ~ay; bin = ~abin;   // operands are free to change now
    end
  endtask

  task automatic run_vec(input logic [31:0] ax, input logic [31:0] ay, input logic abin,
                         input logic [31:0] ed, input logic eb, input logic ez,
                         input logic eo, input int stall);
    logic        ok;
    int          lat;
    logic [31:0] held_d;
    out_ready = (stall == 0);
    accept(ax, ay, abin, ok);
    if (!ok) return;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 64'(lat), 64'd4);
    check("vec_d",    64'(d),    64'(ed));
    check("vec_bout", 64'(bout), 64'(eb));
    check("vec_zero", 64'(zero), 64'(ez));
    check("vec_ovf",  64'(ovf),  64'(eo));
    held_d = d;
    for (int k = 0; k < stall; k++) begin
      // Offer a new transaction that must be ignored while the result waits.
      in_valid = 1'b1;
      x = 32'hA5A5_0000 + 32'(k);
      y = 32'h1;
      @(posedge clk);
      #1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_d",     64'(d),         64'(held_d));
      check("stall_ready", 64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("drop_valid", 64'(out_valid), 64'd0);
    check("back_ready", 64'(in_ready),  64'd1);
  endtask

  initial begin
    logic ok;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; bin = 1'b0;
    #12;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_d",         64'(d),         64'd0);
    check("rst_flags",     64'({bout, zero, ovf}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0);
    run_vec(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    run_vec(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 0);
    run_vec(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 0);
    run_vec(32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 0);
    run_vec(32'h0000_0003, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    run_vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 0);
    run_vec(32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0);
    // Backpressure: result waits three cycles with new requests ignored.
    run_vec(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hCC79_6877, 1'b0, 1'b0, 1'b0, 3);

    // Reset in the middle of BUSY: partial result is discarded.
    out_ready = 1'b1;
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ok);
    if (ok) begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_d",         64'(d),         64'd0);
      check("midrst_in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
        @(posedge clk);
        #1;
        check("midrst_no_valid", 64'(out_valid), 64'd0);
      end
    end
    run_vec(32'd10, 32'd4, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
